// File: rtl/fetch_unit.sv
// Instruction fetch: two-slot memory pipeline feeding a DEPTH-entry queue toward decode.
// Define FETCH_STALL_COUNT_EN to build the decode back-pressure counter on stall_count.
module fetch_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              exec,
    output logic [ADDR_W-1:0] ir_m_addr,
    output logic              ir_m_rw,
    input  logic [DATA_W-1:0] ir_m_q,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ir,
    output logic [ADDR_W-1:0] out_pc,
    output logic [15:0]       stall_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [ADDR_W-1:0] fetch_pc;
    logic              vld_p0, vld_p1;
    logic [ADDR_W-1:0] pc_p0, pc_p1;

    logic [DATA_W-1:0] q_ir [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]  credit_used;
    logic              issue, push, pop;

    // Queued entries plus in-flight slots must stay within DEPTH, so a push never overflows.
    assign credit_used = count + CNT_W'(vld_p0) + CNT_W'(vld_p1);
    assign issue       = (state == RUN) && exec && (credit_used < CNT_W'(DEPTH));
    assign push        = vld_p1;
    assign pop         = out_valid && out_ready;
    assign out_valid   = (count != '0);
    assign out_ir      = q_ir[rd_ptr];
    assign out_pc      = q_pc[rd_ptr];
    assign ir_m_rw     = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= PC0;
            ir_m_addr <= PC0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= exec ? RUN : IDLE;
            if (redirect) begin
                vld_p0 <= exec;
                vld_p1 <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (exec) begin
                    ir_m_addr <= redirect_pc;
                    fetch_pc  <= redirect_pc + 1'b1;
                end else begin
                    fetch_pc  <= redirect_pc;
                end
            end else begin
                vld_p0 <= issue;
                vld_p1 <= vld_p0;
                if (issue) begin
                    ir_m_addr <= fetch_pc;
                    fetch_pc  <= fetch_pc + 1'b1;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // p0: address issued to memory; p1: memory has latched it; push on the next edge.
    always_ff @(posedge clock) begin
        pc_p0 <= redirect ? redirect_pc : fetch_pc;
        pc_p1 <= pc_p0;
        if (push) begin
            q_ir[wr_ptr] <= ir_m_q;
            q_pc[wr_ptr] <= pc_p1;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (out_valid && !out_ready)
            stall_count <= sat_inc16(stall_count);
    end
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected fetch addresses plus directed timing checks.
module tb_fetch_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

`ifdef FETCH_STALL_COUNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset, exec, redirect, out_ready;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] ir_m_addr, out_pc;
    logic              ir_m_rw, out_valid;
    logic [DATA_W-1:0] ir_m_q, out_ir;
    logic [15:0]       stall_count;

    logic [ADDR_W-1:0] w_m_addr, w_pc, w_redirect_pc;
    logic              w_m_rw, w_valid, w_redirect, w_ready;
    logic [DATA_W-1:0] w_m_q, w_ir;
    logic [15:0]       w_stall;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] wrap_exp [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    int wrap_n = 0;

    always #5 clock = ~clock;

    fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4), .RESET_PC(0)) u_dut (
        .clock(clock), .reset(reset), .exec(exec),
        .ir_m_addr(ir_m_addr), .ir_m_rw(ir_m_rw), .ir_m_q(ir_m_q),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc), .stall_count(stall_count)
    );

    fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4), .RESET_PC(12'hFFE)) u_dut_wrap (
        .clock(clock), .reset(reset), .exec(exec),
        .ir_m_addr(w_m_addr), .ir_m_rw(w_m_rw), .ir_m_q(w_m_q),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .out_valid(w_valid), .out_ready(w_ready),
        .out_ir(w_ir), .out_pc(w_pc), .stall_count(w_stall)
    );

    assign w_redirect    = 1'b0;
    assign w_redirect_pc = '0;
    assign w_ready       = 1'b1;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[3:0], a} ^ 16'h5A5A;
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clock) begin
        ir_m_q <= mem_word(ir_m_addr);
        w_m_q  <= mem_word(w_m_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sb_load(input int start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back(ADDR_W'(start + i));
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [ADDR_W-1:0] pc;
                pc = exp_q.pop_front();
                chk("sb_pc", 32'(out_pc), 32'(pc));
                chk("sb_ir", 32'(out_ir), 32'(mem_word(pc)));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && w_valid && wrap_n < 4) begin
            chk("wrap_pc", 32'(w_pc), 32'(wrap_exp[wrap_n]));
            chk("wrap_ir", 32'(w_ir), 32'(mem_word(wrap_exp[wrap_n])));
            wrap_n++;
        end
    end

    initial begin
        reset = 1'b1; exec = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(ir_m_addr), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_rw", 32'(ir_m_rw), 32'd0);

        // Startup: IDLE->RUN edge, issue next edge, push two edges after that.
        sb_load(0, 64);
        reset = 1'b0; exec = 1'b1;
        step(1);
        chk("lat_e0_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        chk("lat_e1_addr", 32'(ir_m_addr), 32'd0);
        step(1);
        chk("lat_e2_valid", 32'(out_valid), 32'd0);
        chk("lat_e2_addr", 32'(ir_m_addr), 32'd1);
        step(1);
        chk("lat_e3_valid", 32'(out_valid), 32'd1);
        chk("lat_e3_pc", 32'(out_pc), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", 32'(out_pc), 32'(i));
        end

        // Back-pressure: head stays at pc 3, queue fills with 3..6, fetch stops at 6.
        out_ready = 1'b0;
        step(7);
        chk("stall7", 32'(stall_count), STALL_EN ? 32'd7 : 32'd0);
        step(3);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_pc), 32'd3);
        chk("bp_addr", 32'(ir_m_addr), 32'd6);
        chk("stall10", 32'(stall_count), STALL_EN ? 32'd10 : 32'd0);
        step(2);
        chk("bp_addr_hold", 32'(ir_m_addr), 32'd6);
        chk("bp_head_hold", 32'(out_pc), 32'd3);
        out_ready = 1'b1;
        step(8);

        // Build 3 queued entries plus one in flight, then redirect to 0x100.
        out_ready = 1'b0;
        step(2);
        chk("pre_redir_valid", 32'(out_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 12'h100;
        step(1);
        redirect = 1'b0;
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", 32'(ir_m_addr), 32'h100);
        sb_load(12'h100, 32);
        out_ready = 1'b1;
        step(1);
        chk("redir_e1_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("redir_e2_valid", 32'(out_valid), 32'd1);
        chk("redir_e2_pc", 32'(out_pc), 32'h100);
        step(6);

        // Mid-stream reset with both in-flight slots busy.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        sb_load(0, 16);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_addr", 32'(ir_m_addr), 32'd0);
        chk("mrst_stall", 32'(stall_count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("mrst_no_push", 32'(out_valid), 32'd0);
        end
        step(1);
        chk("mrst_valid_up", 32'(out_valid), 32'd1);
        chk("mrst_first_pc", 32'(out_pc), 32'd0);
        step(4);

        chk("wrap_count", 32'(wrap_n), 32'd4);
        chk("rw_end", 32'(ir_m_rw), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning instruction-memory address width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of 2, >= 4).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port exec, input, 1, meaning run enable; new fetches are issued only while high.
REQ-008 SHALL have port ir_m_addr, output, ADDR_W, meaning registered instruction-memory address.
REQ-009 SHALL have port ir_m_rw, output, 1, meaning memory write enable, constant 0.
REQ-010 SHALL have port ir_m_q, input, DATA_W, meaning the word at the address the memory latched on the previous edge.
REQ-011 SHALL have port redirect, input, 1, meaning branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc, input, ADDR_W, meaning the new fetch address.
REQ-013 SHALL have port out_valid, output, 1, meaning out_ir/out_pc hold a valid instruction.
REQ-014 SHALL have port out_ready, input, 1, meaning the decode stage accepts; pop when out_valid && out_ready.
REQ-015 SHALL have port out_ir, output, DATA_W, meaning the instruction at the queue head.
REQ-016 SHALL have port out_pc, output, ADDR_W, meaning the address of out_ir.
REQ-017 SHALL have port stall_count, output, 16, meaning the decode back-pressure counter (see Configuration).

Function
REQ-018 SHALL implement states IDLE and RUN: IDLE->RUN when exec=1; RUN->IDLE when exec=0; a request issues on an edge only in RUN with exec=1.
REQ-019 SHALL issue a request by loading ir_m_addr<=fetch_pc and fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, wrap to 0) when occupancy + in-flight count < DEPTH.
REQ-020 SHALL track two in-flight slots (memory latches ir_m_addr one edge after issue; ir_m_q is pushed with its pc tag on the following edge), so issue-to-push is 2 edges.
REQ-021 SHALL drive out_valid = queue not empty, with out_ir/out_pc taken from the head entry combinationally from queue registers.
REQ-022 SHALL allow a push and a pop on the same edge at any occupancy, including full; occupancy is then unchanged.
REQ-023 SHALL never overflow; the credit check alone prevents a push into a full queue.
REQ-024 SHALL sustain one instruction per cycle when out_ready is held at 1.
REQ-025 SHALL on a redirect sampled at edge k: clear the queue, squash both in-flight slots, set ir_m_addr<=redirect_pc and fetch_pc<=redirect_pc+1 if exec=1, else fetch_pc<=redirect_pc with ir_m_addr unchanged.
REQ-026 SHALL give redirect priority over a simultaneous pop or push; the popped or pushed data is discarded.
REQ-027 SHALL keep draining the queue and completing in-flight pushes while exec=0.
REQ-028 SHALL hold ir_m_rw at 0 at all times.

Reset
REQ-029 SHALL on reset=1 at an edge: state IDLE, fetch_pc=RESET_PC, ir_m_addr=RESET_PC, queue empty (out_valid=0), in-flight slots cleared, stall_count=0.
REQ-030 SHALL abort any operation in progress on reset and discard in-flight responses; reset overrides redirect.
REQ-031 SHALL leave out_ir/out_pc undefined but harmless while out_valid=0.

Configuration
REQ-032 SHALL, with macro FETCH_STALL_COUNT_EN defined, increment stall_count each cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF, and clear it on reset.
REQ-033 SHALL, without FETCH_STALL_COUNT_EN, tie stall_count to 0 and contain no counter logic.

Verification
REQ-034 SHALL cover reset, then exec=1 from edge 1 with out_ready=1: out_valid rises after edge 3 with out_pc=0, then pc 1,2,3 on consecutive cycles.
REQ-035 SHALL cover out_ready=0 for 10 cycles: occupancy reaches DEPTH=4, ir_m_addr stops advancing, no entry is lost, and order is 0..n after release.
REQ-036 SHALL cover redirect with redirect_pc=12'h100 while 3 entries are queued: out_valid=0 after that edge, the next out_pc is 12'h100 two edges later, and no stale pc appears.
REQ-037 SHALL cover RESET_PC=12'hFFE: out_pc sequence FFE, FFF, 000, 001 (wrap-around).
REQ-038 SHALL cover reset asserted mid-stream with 2 in-flight requests: no push follows, and the first out_pc after reset is RESET_PC.
REQ-039 SHALL cover, with FETCH_STALL_COUNT_EN defined, 7 cycles of out_valid=1/out_ready=0 -> stall_count=7; without the macro -> stall_count=0.
